// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter for the io peripheral bus, with burst cap, owner lock and
// tag-routed read return.
module io_bus_arbiter #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_din,
  input  logic              m0_w_en,
  input  logic              m0_r_en,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_dout,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_din,
  input  logic              m1_w_en,
  input  logic              m1_r_en,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_dout,
  output logic              m1_rvalid,
  output logic [ADDR_W-1:0] s_address,
  output logic [DATA_W-1:0] s_din,
  output logic              s_w_en,
  output logic              s_r_en,
  input  logic [DATA_W-1:0] s_dout
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] burst_q, burst_d, burst_inc;
  logic            ptr_q, ptr_d;  // 1: m1 wins the next contention
  logic            rd_pend_q, rd_pend_d;
  logic            rd_tag_q, rd_tag_d;
  logic            access, cap_hit;

  // Strobes are gated by rst so nothing reaches the peripheral while resetting.
  always_comb begin
    s_address = m0_address;
    s_din     = m0_din;
    s_w_en    = 1'b0;
    s_r_en    = 1'b0;
    unique case (state_q)
      StOwn0: begin
        s_w_en = m0_w_en & ~rst;
        s_r_en = m0_r_en & ~rst;
      end
      StOwn1: begin
        s_address = m1_address;
        s_din     = m1_din;
        s_w_en    = m1_w_en & ~rst;
        s_r_en    = m1_r_en & ~rst;
      end
      default: ;
    endcase
  end

  assign access    = s_w_en | s_r_en;
  assign burst_inc = (access && burst_q != CntMax) ? burst_q + CntW'(1) : burst_q;
  assign cap_hit   = burst_inc >= CntMax;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (m0_req && m1_req) state_d = ptr_q ? StOwn1 : StOwn0;
        else if (m0_req)      state_d = StOwn0;
        else if (m1_req)      state_d = StOwn1;
      end
      StOwn0: begin
        if (!m0_req)                           state_d = m1_req ? StOwn1 : StIdle;
        else if (m1_req && !m0_lock && cap_hit) state_d = StOwn1;
      end
      StOwn1: begin
        if (!m1_req)                           state_d = m0_req ? StOwn0 : StIdle;
        else if (m0_req && !m1_lock && cap_hit) state_d = StOwn0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    burst_d = (state_d == state_q) ? burst_inc : '0;
    ptr_d   = ptr_q;
    if (state_d == StOwn0 && state_q != StOwn0)      ptr_d = 1'b1;
    else if (state_d == StOwn1 && state_q != StOwn1) ptr_d = 1'b0;
    rd_pend_d = s_r_en;
    rd_tag_d  = (state_q == StOwn1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      burst_q   <= '0;
      ptr_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      ptr_q     <= ptr_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

  assign m0_gnt    = (state_q == StOwn0);
  assign m1_gnt    = (state_q == StOwn1);
  assign m0_rvalid = rd_pend_q & ~rd_tag_q;
  assign m1_rvalid = rd_pend_q & rd_tag_q;
  assign m0_dout   = s_dout;
  assign m1_dout   = s_dout;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: an ownership/tenure model checked every cycle, plus
// hand-computed literal expectations for the key scenarios.
module tb_io_bus_arbiter;

  localparam int MaxBurst = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = '0, lock = '0, w_en = '0, r_en = '0;
  logic [7:0] addr [2];
  logic [7:0] din  [2];
  logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_w_en, s_r_en;
  logic [7:0] m0_dout, m1_dout, s_address, s_din;
  logic [7:0] s_dout = 8'h00;
  logic [7:0] pmem [256];
  logic [7:0] mmem [256];

  int vectors = 0, miscompares = 0;
  int m0_wr_cnt = 0;

  io_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(MaxBurst)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_lock(lock[0]), .m0_address(addr[0]), .m0_din(din[0]),
    .m0_w_en(w_en[0]), .m0_r_en(r_en[0]), .m0_gnt(m0_gnt), .m0_dout(m0_dout),
    .m0_rvalid(m0_rvalid),
    .m1_req(req[1]), .m1_lock(lock[1]), .m1_address(addr[1]), .m1_din(din[1]),
    .m1_w_en(w_en[1]), .m1_r_en(r_en[1]), .m1_gnt(m1_gnt), .m1_dout(m1_dout),
    .m1_rvalid(m1_rvalid),
    .s_address(s_address), .s_din(s_din), .s_w_en(s_w_en), .s_r_en(s_r_en),
    .s_dout(s_dout)
  );

  always #5 clk = ~clk;

  // Peripheral: read data one cycle after r_en, read-before-write.
  always @(posedge clk) begin
    if (s_r_en) s_dout <= pmem[s_address];
    if (s_w_en) pmem[s_address] <= s_din;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: owner (-1 none), accesses in current tenure, favoured master, pending read.
  int         own = -1, used = 0, fav = 0, ptag = 0;
  bit         pend = 0, armed = 0;
  logic [7:0] pdata = 8'h00;

  always @(posedge clk) begin : model
    int n_own, n_used, n_fav, oth;
    bit rd, wr;
    logic [7:0] a, d;
    n_own  = own;
    n_used = used;
    n_fav  = fav;
    rd = 1'b0;
    wr = 1'b0;
    a  = addr[0];
    d  = din[0];
    if (own >= 0) begin
      rd = r_en[own];
      wr = w_en[own];
      a  = addr[own];
      d  = din[own];
    end
    if (rst) begin
      n_own = -1; n_used = 0; n_fav = 0; rd = 1'b0; wr = 1'b0;
    end else begin
      if (rd || wr) n_used = used + 1;
      oth = 1 - own;
      if (own < 0) begin
        if (req == 2'b11)  n_own = fav;
        else if (req[0])   n_own = 0;
        else if (req[1])   n_own = 1;
      end else if (!req[own]) begin
        n_own = req[oth] ? oth : -1;
      end else if (req[oth] && !lock[own] && n_used >= MaxBurst) begin
        n_own = oth;
      end
      if (n_own != own) begin
        n_used = 0;
        if (n_own >= 0) n_fav = 1 - n_own;
      end
    end
    pend  <= rd;
    ptag  <= own;
    pdata <= mmem[a];
    if (wr) mmem[a] <= d;
    own   <= n_own;
    used  <= n_used;
    fav   <= n_fav;
    armed <= 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin : compare
      logic ew, er;
      logic [7:0] ea, ed;
      ew = 1'b0; er = 1'b0; ea = addr[0]; ed = din[0];
      if (own >= 0) begin
        ew = !rst && w_en[own];
        er = !rst && r_en[own];
        ea = addr[own];
        ed = din[own];
      end
      if (m0_gnt && s_w_en) m0_wr_cnt++;
      chk("m0_gnt", 32'(m0_gnt), 32'(own == 0));
      chk("m1_gnt", 32'(m1_gnt), 32'(own == 1));
      chk("s_w_en", 32'(s_w_en), 32'(ew));
      chk("s_r_en", 32'(s_r_en), 32'(er));
      chk("s_address", 32'(s_address), 32'(ea));
      chk("s_din", 32'(s_din), 32'(ed));
      chk("m0_rvalid", 32'(m0_rvalid), 32'(pend && ptag == 0));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(pend && ptag == 1));
      chk("m0_dout_passthru", 32'(m0_dout), 32'(s_dout));
      chk("m1_dout_passthru", 32'(m1_dout), 32'(s_dout));
      if (pend) chk("read_data", 32'(ptag == 1 ? m1_dout : m0_dout), 32'(pdata));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c0;
    for (int i = 0; i < 256; i++) begin
      pmem[i] = 8'(i) ^ 8'h5A;
      mmem[i] = 8'(i) ^ 8'h5A;
    end
    pmem[8'h08] = 8'h3C;
    mmem[8'h08] = 8'h3C;
    addr[0] = 8'h33; din[0] = 8'h00; addr[1] = 8'h00; din[1] = 8'h00;

    // Reset holds grant low even with a request and a write strobe pending.
    rst = 1'b1; req = 2'b01; w_en = 2'b01;
    step(); step();
    chk("rst_gnt0", 32'(m0_gnt), 32'd0);
    chk("rst_s_w_en", 32'(s_w_en), 32'd0);
    rst = 1'b0; w_en = 2'b00;
    step();
    chk("post_rst_gnt0", 32'(m0_gnt), 32'd1);

    // Combinational write forwarding.
    addr[0] = 8'h01; din[0] = 8'hA5; w_en[0] = 1'b1;
    #1;
    chk("fwd_addr", 32'(s_address), 32'h01);
    chk("fwd_din", 32'(s_din), 32'hA5);
    chk("fwd_w_en", 32'(s_w_en), 32'd1);
    step();
    w_en[0] = 1'b0;

    // Direct handover to m1, then a read routed back to m1.
    req = 2'b10;
    step();
    chk("handover_gnt1", 32'(m1_gnt), 32'd1);
    r_en[1] = 1'b1; addr[1] = 8'h08;
    step();
    r_en[1] = 1'b0;
    chk("m1_rvalid", 32'(m1_rvalid), 32'd1);
    chk("m1_dout", 32'(m1_dout), 32'h3C);
    chk("m0_rvalid_quiet", 32'(m0_rvalid), 32'd0);

    // Burst cap: both requesting from reset, m0 writes every cycle.
    req = 2'b00;
    step();
    rst = 1'b1; req = 2'b11; w_en = 2'b01; addr[0] = 8'h40; din[0] = 8'h11;
    step();
    rst = 1'b0;
    c0 = m0_wr_cnt;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m1_gnt) break;
    end
    chk("burst_writes", 32'(m0_wr_cnt - c0), 32'd4);
    chk("burst_gnt1", 32'(m1_gnt), 32'd1);
    chk("burst_gnt0", 32'(m0_gnt), 32'd0);
    w_en = 2'b00; req = 2'b00;
    step();
    req = 2'b11;
    step();
    chk("rr_next_m0", 32'(m0_gnt), 32'd1);

    // Lock extends the tenure past the cap; dropping it hands over on the next edge.
    rst = 1'b1; req = 2'b11; lock = 2'b01; w_en = 2'b01;
    step();
    rst = 1'b0;
    step();
    c0 = m0_wr_cnt;
    repeat (10) step();
    chk("lock_writes", 32'(m0_wr_cnt - c0), 32'd10);
    chk("lock_gnt0", 32'(m0_gnt), 32'd1);
    lock = 2'b00;
    step();
    chk("unlock_gnt1", 32'(m1_gnt), 32'd1);

    // Non-owner strobes dropped; owner's last-cycle read returns after handover.
    rst = 1'b1; req = 2'b11; w_en = 2'b11; addr[1] = 8'h20; din[1] = 8'hEE;
    step();
    rst = 1'b0;
    step();
    repeat (3) step();
    w_en[0] = 1'b0; r_en[0] = 1'b1; addr[0] = 8'h08;
    #1;
    chk("drop_s_w_en", 32'(s_w_en), 32'd0);
    chk("last_s_r_en", 32'(s_r_en), 32'd1);
    chk("periph_untouched", 32'(pmem[8'h20]), 32'h7A);
    step();
    r_en[0] = 1'b0;
    chk("late_gnt1", 32'(m1_gnt), 32'd1);
    chk("late_m0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("late_m0_dout", 32'(m0_dout), 32'h3C);
    chk("late_m1_rvalid", 32'(m1_rvalid), 32'd0);

    // Reset while a read is being issued cancels it.
    r_en[1] = 1'b1; addr[1] = 8'h08; rst = 1'b1;
    step();
    r_en = 2'b00; rst = 1'b0; w_en = 2'b00; req = 2'b00;
    chk("rst_cancel_rvalid", 32'(m1_rvalid), 32'd0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
